// File: rtl/clock_pkg.sv
// Shared encodings and limits for the digital-clock datapath.
// The mode encoding is visible on the clock_ctrl mode port and is also used by
// the display logic; the *_MAX limits are shared with the sec/min/hour counters.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_SET_H = 2'd1,
    MODE_SET_M = 2'd2
  } mode_e;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

endpackage

// File: rtl/clock_ctrl_if.sv
// Connects clock_ctrl to the tick divider, the button conditioner and the
// sec/min/hour counter blocks.
// Modports:
//   master - the surrounding datapath: drives the tick, max flags and buttons,
//            and receives the strobes.
//   slave  - clock_ctrl itself.
import clock_pkg::*;

interface clock_ctrl_if;
  logic       tick;
  logic       sec_max;
  logic       min_max;
  logic       btn_mode;
  logic       btn_inc;
  logic       sec_inc;
  logic       min_inc;
  logic       hour_inc;
  logic       sec_clr;
  logic [1:0] mode;
  logic       blink;

  modport master (
    output tick, sec_max, min_max, btn_mode, btn_inc,
    input  sec_inc, min_inc, hour_inc, sec_clr, mode, blink
  );

  modport slave (
    input  tick, sec_max, min_max, btn_mode, btn_inc,
    output sec_inc, min_inc, hour_inc, sec_clr, mode, blink
  );
endinterface

// File: rtl/clock_ctrl_timeout.sv
// Inactivity timer for the time-set modes.
// Counts ticks since the last clear. expire is asserted combinationally in the
// cycle of the SET_TIMEOUT-th tick, unless a clear arrives in that same cycle,
// because a button press always outranks the timeout. The counter returns to 0
// on expiry, so it never saturates.
module clock_ctrl_timeout #(
  parameter int SET_TIMEOUT = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic expire
);

  localparam int CW = $clog2(SET_TIMEOUT + 1);
  localparam logic [CW-1:0] TC = CW'(SET_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire = tick && !clr && (cnt_q == TC);

  // next count: clear wins, then expiry wrap, then tick increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr || expire) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // counter register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clock_ctrl.sv
// Sequencer for the digital-clock datapath.
// It runs time from a 1 Hz tick, chaining carries into the minutes and hours.
// It also provides a button-driven time-set mode: hours first, then minutes.
// All outputs are registered, so every strobe appears exactly one cycle after
// the input cycle that causes it.
// Optional feature macro: CLOCK_CTRL_BLINK_EN enables the blink output.
// Without this macro, blink is tied to 0.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   MODE_RUN   | time runs from tick with carry chaining; btn_inc ignored
//   MODE_SET_H | time halted; btn_inc bumps hours only; timeout active
//   MODE_SET_M | time halted; btn_inc bumps minutes only; timeout active
import clock_pkg::*;

module clock_ctrl #(
  parameter int SET_TIMEOUT = 30
) (
  input  logic         clk,
  input  logic         rst,
  clock_ctrl_if.slave  bus
);

  mode_e mode_q, mode_d;
  logic  sec_inc_q, sec_inc_d;
  logic  min_inc_q, min_inc_d;
  logic  hour_inc_q, hour_inc_d;
  logic  sec_clr_q, sec_clr_d;

  logic  in_set;
  logic  to_clr;
  logic  to_expire;

  assign in_set = (mode_q != MODE_RUN);

  // The counter is held clear in RUN, which also clears it on entry to a set
  // mode. Any button press restarts it.
  assign to_clr = !in_set || bus.btn_mode || bus.btn_inc;

  clock_ctrl_timeout #(
    .SET_TIMEOUT (SET_TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (to_clr),
    .tick   (bus.tick && in_set),
    .expire (to_expire)
  );

  // next mode and strobes; btn_mode outranks btn_inc, which outranks timeout
  always_comb begin
    mode_d     = mode_q;
    sec_inc_d  = 1'b0;
    min_inc_d  = 1'b0;
    hour_inc_d = 1'b0;
    sec_clr_d  = 1'b0;
    case (mode_q)
      MODE_RUN: begin
        if (bus.tick) begin
          sec_inc_d  = 1'b1;
          min_inc_d  = bus.sec_max;
          hour_inc_d = bus.sec_max && bus.min_max;
        end
        if (bus.btn_mode) begin
          mode_d = MODE_SET_H;
        end
      end
      MODE_SET_H: begin
        if (bus.btn_mode) begin
          mode_d = MODE_SET_M;
        end else if (bus.btn_inc) begin
          hour_inc_d = 1'b1;
        end else if (to_expire) begin
          mode_d    = MODE_RUN;
          sec_clr_d = 1'b1;
        end
      end
      MODE_SET_M: begin
        if (bus.btn_mode) begin
          mode_d    = MODE_RUN;
          sec_clr_d = 1'b1;
        end else if (bus.btn_inc) begin
          min_inc_d = 1'b1;
        end else if (to_expire) begin
          mode_d    = MODE_RUN;
          sec_clr_d = 1'b1;
        end
      end
      default: begin
        mode_d = MODE_RUN;
      end
    endcase
  end

  // FSM state and registered strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= MODE_RUN;
      sec_inc_q  <= 1'b0;
      min_inc_q  <= 1'b0;
      hour_inc_q <= 1'b0;
      sec_clr_q  <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      sec_inc_q  <= sec_inc_d;
      min_inc_q  <= min_inc_d;
      hour_inc_q <= hour_inc_d;
      sec_clr_q  <= sec_clr_d;
    end
  end

  assign bus.mode     = mode_q;
  assign bus.sec_inc  = sec_inc_q;
  assign bus.min_inc  = min_inc_q;
  assign bus.hour_inc = hour_inc_q;
  assign bus.sec_clr  = sec_clr_q;

`ifdef CLOCK_CTRL_BLINK_EN
  logic blink_q, blink_d;

  // blink restarts lit on entering a set mode, toggles per tick, dark in RUN
  always_comb begin
    blink_d = blink_q;
    if (mode_d == MODE_RUN) begin
      blink_d = 1'b0;
    end else if (mode_d != mode_q) begin
      blink_d = 1'b1;
    end else if (bus.tick) begin
      blink_d = !blink_q;
    end
  end

  // blink register
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
    end
  end

  assign bus.blink = blink_q;
`else
  assign bus.blink = 1'b0;
`endif

endmodule
